// File: rtl/clk_meas_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : clk_meas_pkg
// Description : Shared definitions for the clock period meter: FSM state
//               encoding and the default counter width.  The default width
//               matches the divisor width of the programmable clock divider,
//               so a divided clock can always be read back in full.
// Revision    : 1.0 - initial release
// ============================================================================
package clk_meas_pkg;

    // Default period/high-time counter width (same as divider n width)
    localparam int C_CNT_W_DEFAULT = 31;

    // Measurement FSM states, 2-bit encoding
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_MEASURE = 2'd2,
        ST_TIMEOUT = 2'd3
    } meas_state_t;

endpackage : clk_meas_pkg
`default_nettype wire

// File: rtl/sync_edge_det.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : sync_edge_det
// Description : SYNC_STAGES-flop synchronizer followed by a registered edge
//               detector.  Rise and fall pulses share the same latency
//               (SYNC_STAGES+1 cycles from input change), so pulse widths
//               measured between them are preserved exactly.
//               No edge is reported until the synchronizer and the level
//               register hold genuinely sampled values, so the value left in
//               the flops by reset never produces a spurious edge.
// Ports       : clk_i   in  1  sampling clock
//               rst_i   in  1  asynchronous active-high reset
//               sig_i   in  1  asynchronous input
//               level_o out 1  synchronized level (aligned with the pulses)
//               rise_o  out 1  one-cycle pulse on synchronized rising edge
//               fall_o  out 1  one-cycle pulse on synchronized falling edge
// Revision    : 1.0 - initial release
// ============================================================================
module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sig_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    // Shifts in ones after reset; the top bit marks that both the last
    // synchronizer stage and level_q hold real samples.
    logic [SYNC_STAGES:0]   fill_q;
    logic                   level_q;
    logic                   rise_q;
    logic                   fall_q;
    logic                   primed;
    logic                   sync_lvl;

    assign primed   = fill_q[SYNC_STAGES];
    assign sync_lvl = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q  <= '0;
            fill_q  <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], sig_i};
            fill_q  <= {fill_q[SYNC_STAGES-1:0], 1'b1};
            level_q <= sync_lvl;
            rise_q  <= primed &  sync_lvl & ~level_q;
            fall_q  <= primed & ~sync_lvl &  level_q;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule : sync_edge_det
`default_nettype wire

// File: rtl/clk_period_meter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : clk_period_meter
// Description : Measures a slow, possibly asynchronous signal in CLK_in
//               cycles: period (rise-to-rise) and optionally high time
//               (rise-to-fall).  A divided clock with divisor n reads back
//               period == n.  Reports a lock flag when two consecutive
//               periods match and a timeout when no rising edge arrives
//               within 2^CNT_W-1 cycles.
// Config      : CLK_PMETER_DUTY_EN - when defined, the high-time counter is
//               built; otherwise high_time is tied to zero.
// Ports       : CLK_in    in  1      measurement clock
//               rst       in  1      asynchronous active-high reset
//               sig_in    in  1      signal under measurement
//               period    out CNT_W  last complete period
//               high_time out CNT_W  last complete high time
//               valid     out 1      period updated this cycle
//               locked    out 1      last two periods equal
//               timeout   out 1      no rising edge within limit
// Revision    : 1.0 - initial release
// ============================================================================
module clk_period_meter
    import clk_meas_pkg::*;
#(
    parameter int CNT_W       = C_CNT_W_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic             CLK_in,
    input  logic             rst,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    output logic             locked,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    // Count value from which the next increment reaches the limit
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_MAX - CNT_ONE;

    logic level;
    logic rise;
    logic fall;

    sync_edge_det #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge_det (
        .clk_i   (CLK_in),
        .rst_i   (rst),
        .sig_i   (sig_in),
        .level_o (level),
        .rise_o  (rise),
        .fall_o  (fall)
    );

    meas_state_t      state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [CNT_W-1:0] period_q,  period_d;
    logic             valid_q,   valid_d;
    logic             locked_q,  locked_d;
    logic             timeout_q, timeout_d;
    // A previous period exists to compare against (cleared on timeout)
    logic             prev_ok_q, prev_ok_d;

    always_ff @(posedge CLK_in or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            locked_q  <= 1'b0;
            timeout_q <= 1'b0;
            prev_ok_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            valid_q   <= valid_d;
            locked_q  <= locked_d;
            timeout_q <= timeout_d;
            prev_ok_q <= prev_ok_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        period_d  = period_q;
        valid_d   = 1'b0;
        locked_d  = locked_q;
        timeout_d = timeout_q;
        prev_ok_d = prev_ok_q;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_ARMED;
            end
            ST_ARMED: begin
                // First edge only starts the count; nothing to report yet
                if (rise) begin
                    cnt_d   = CNT_ONE;
                    state_d = ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                // Rise takes priority over reaching the limit
                if (rise) begin
                    period_d  = cnt_q;
                    valid_d   = 1'b1;
                    locked_d  = prev_ok_q && (cnt_q == period_q);
                    prev_ok_d = 1'b1;
                    cnt_d     = CNT_ONE;
                end else if (cnt_q == CNT_LIMIT) begin
                    cnt_d     = CNT_MAX;
                    timeout_d = 1'b1;
                    locked_d  = 1'b0;
                    prev_ok_d = 1'b0;
                    state_d   = ST_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_TIMEOUT: begin
                if (rise) begin
                    timeout_d = 1'b0;
                    cnt_d     = CNT_ONE;
                    state_d   = ST_MEASURE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign period  = period_q;
    assign valid   = valid_q;
    assign locked  = locked_q;
    assign timeout = timeout_q;

`ifdef CLK_PMETER_DUTY_EN
    logic [CNT_W-1:0] hcnt_q,  hcnt_d;
    logic [CNT_W-1:0] high_q,  high_d;
    // A rise has been seen since arming / timeout, so a fall is meaningful
    logic             hseen_q, hseen_d;

    always_ff @(posedge CLK_in or posedge rst) begin
        if (rst) begin
            hcnt_q  <= '0;
            high_q  <= '0;
            hseen_q <= 1'b0;
        end else begin
            hcnt_q  <= hcnt_d;
            high_q  <= high_d;
            hseen_q <= hseen_d;
        end
    end

    always_comb begin
        hcnt_d  = hcnt_q;
        high_d  = high_q;
        hseen_d = hseen_q;

        if (rise && (state_q != ST_IDLE)) begin
            hcnt_d  = CNT_ONE;
            hseen_d = 1'b1;
        end else begin
            if (fall && hseen_q) begin
                high_d = hcnt_q;
            end
            if (level && (hcnt_q != CNT_MAX)) begin
                hcnt_d = hcnt_q + CNT_ONE;
            end
        end

        if ((state_d == ST_TIMEOUT) && (state_q != ST_TIMEOUT)) begin
            hseen_d = 1'b0;
        end
    end

    assign high_time = high_q;
`else
    logic unused_edge;
    assign unused_edge = &{1'b0, level, fall};
    assign high_time   = '0;
`endif

endmodule : clk_period_meter
`default_nettype wire

// File: tb/tb_clk_period_meter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_clk_period_meter
// Description : Self-checking bench for clk_period_meter (CNT_W = 8).
//               A table of signal periods is driven and the resulting valid
//               pulses are compared in order against hand-computed values;
//               timeout, reset abort and constant-high cases are separate
//               hand-written sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_period_meter;

    localparam int W = 8;
`ifdef CLK_PMETER_DUTY_EN
    localparam bit DUTY = 1'b1;
`else
    localparam bit DUTY = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         sig;
    logic [W-1:0] period;
    logic [W-1:0] high_time;
    logic         valid;
    logic         locked;
    logic         timeout;

    clk_period_meter #(
        .CNT_W       (W),
        .SYNC_STAGES (2)
    ) dut (
        .CLK_in    (clk),
        .rst       (rst),
        .sig_in    (sig),
        .period    (period),
        .high_time (high_time),
        .valid     (valid),
        .locked    (locked),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int p;
        int l;
        int h;
        int c;
    } obs_t;
    obs_t obs_q[$];
    obs_t mon_o;

    always @(negedge clk) begin
        if (!rst && valid) begin
            mon_o.p = int'(period);
            mon_o.l = int'(locked);
            mon_o.h = int'(high_time);
            mon_o.c = cyc;
            obs_q.push_back(mon_o);
        end
    end

    typedef struct {
        int n;
        int h;
        bit exp_v;
        int exp_p;
        int exp_l;
        int exp_h;
    } vec_t;
    vec_t vecs[13];

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic int eh(input int h);
        return DUTY ? h : 0;
    endfunction

    // One full period of the divided clock: high for h cycles, low for n-h
    task automatic drive_period(input int n, input int h);
        for (int i = 0; i < n; i++) begin
            sig = (i < h);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_period"},  int'(period),    0);
        check({tag, "_high"},    int'(high_time), 0);
        check({tag, "_valid"},   int'(valid),     0);
        check({tag, "_locked"},  int'(locked),    0);
        check({tag, "_timeout"}, int'(timeout),   0);
    endtask

    task automatic check_obs(input string tag, input int idx, input int p, input int l);
        if (idx < obs_q.size()) begin
            check({tag, "_period"}, obs_q[idx].p, p);
            check({tag, "_locked"}, obs_q[idx].l, l);
        end else begin
            check({tag, "_present"}, 0, 1);
        end
    endtask

    int nexp;
    int k;
    int vlast;

    initial begin
        // Entry i: period driven; expectation is for the valid produced by
        // the rise that starts entry i (it measures entry i-1).
        vecs[0]  = '{10, 5, 1'b0,  0, 0, 0};
        vecs[1]  = '{10, 5, 1'b1, 10, 0, 5};
        vecs[2]  = '{10, 5, 1'b1, 10, 1, 5};
        vecs[3]  = '{10, 5, 1'b1, 10, 1, 5};
        vecs[4]  = '{ 7, 4, 1'b1, 10, 1, 5};
        vecs[5]  = '{ 7, 4, 1'b1,  7, 0, 4};
        vecs[6]  = '{ 7, 4, 1'b1,  7, 1, 4};
        vecs[7]  = '{10, 5, 1'b1,  7, 1, 4};
        vecs[8]  = '{10, 5, 1'b1, 10, 0, 5};
        vecs[9]  = '{12, 6, 1'b1, 10, 1, 5};
        vecs[10] = '{12, 6, 1'b1, 12, 0, 6};
        vecs[11] = '{12, 6, 1'b1, 12, 1, 6};
        vecs[12] = '{12, 6, 1'b1, 12, 1, 6};

        // ---- reset state ----
        rst = 1'b1;
        sig = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        obs_q.delete();

        // ---- table: steady, 10->7, 7->10, 10->12 ----
        nexp = 0;
        foreach (vecs[i]) begin
            drive_period(vecs[i].n, vecs[i].h);
            if (vecs[i].exp_v) nexp++;
        end
        check("valid_count", obs_q.size(), nexp);
        k = 0;
        foreach (vecs[i]) begin
            if (vecs[i].exp_v) begin
                if (k < obs_q.size()) begin
                    check($sformatf("vec%0d_period", i), obs_q[k].p, vecs[i].exp_p);
                    check($sformatf("vec%0d_locked", i), obs_q[k].l, vecs[i].exp_l);
                    check($sformatf("vec%0d_high", i),   obs_q[k].h, eh(vecs[i].exp_h));
                end
                k++;
            end
        end

        // ---- timeout: 255 cycles after last rise (valid is one cycle after rise) ----
        vlast = (obs_q.size() > 0) ? obs_q[obs_q.size()-1].c : cyc;
        while (cyc < vlast + 253) @(negedge clk);
        check("timeout_early", int'(timeout), 0);
        @(negedge clk);
        check("timeout_set",   int'(timeout), 1);
        check("timeout_locked", int'(locked), 0);
        check("timeout_period", int'(period), 12);

        // ---- recovery: first rise clears timeout without valid ----
        @(posedge clk);
        #1;
        obs_q.delete();
        drive_period(10, 5);
        check("timeout_clear", int'(timeout), 0);
        check("no_valid_after_timeout", obs_q.size(), 0);
        drive_period(10, 5);
        sig = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("recover_count", obs_q.size(), 2);
        check_obs("recover0", 0, 10, 0);
        check_obs("recover1", 1, 10, 1);

        // ---- reset four cycles into a measurement ----
        sig = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        sig = 1'b1;
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_zero("abort");
        sig = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        obs_q.delete();
        drive_period(10, 5);
        check("post_reset_first", obs_q.size(), 0);
        drive_period(8, 4);
        sig = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("post_reset_count", obs_q.size(), 2);
        check_obs("post_reset0", 0, 10, 0);
        check_obs("post_reset1", 1, 8, 0);

        // ---- constant high from reset: no edge, ARMED never times out ----
        @(negedge clk);
        rst = 1'b1;
        sig = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        obs_q.delete();
        repeat (300) @(posedge clk);
        #1;
        check("const_high_valids", obs_q.size(), 0);
        check_zero("const_high");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_clk_period_meter
`default_nettype wire
